hazard_sb: RTL and testbench
============================

HAZARD_SB -- requirements
Module: hazard_sb

Interface
- REQ-001 Parameter AW, default 5, register-address width.
- REQ-002 Parameter LAT_W, default 4, width of the multi-cycle latency field.
- REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
- REQ-004 Port rst, input, 1, reset, asynchronous and active-high.
- REQ-005 Ports rsD, rtD, writeregD, input, AW each, decode-stage source and destination registers.
- REQ-006 Ports branchD, regwriteD, issueD, mcopD, input, 1 each: branch, register-write, valid instruction, and multi-cycle op (mul/div), all in D.
- REQ-007 Port mclatD, input, LAT_W, execute latency of the D multi-cycle op, in cycles.
- REQ-008 Ports rsE, rtE, writeregE, input, AW each; regwriteE, memtoregE, input, 1 each.
- REQ-009 Ports writeregM, input, AW; regwriteM, memtoregM, input, 1 each.
- REQ-010 Ports writeregW, input, AW; regwriteW, input, 1.
- REQ-011 Port mispredictE, input, 1, the predictor resolved a wrong direction or target in E.
- REQ-012 Ports stallF, stallD, flushD, flushE, output, 1 each; all are active-high.
- REQ-013 Ports forwardaD, forwardbD, output, 1 each; forwardaE, forwardbE, output, 2 each.
- REQ-014 Port mcbusy, output, 1, multi-cycle unit occupied.

Function
- REQ-015 Any forward to or from register 0 SHALL NOT occur, on every path.
- REQ-016 forwardaD SHALL be 1 when rsD!=0, rsD==writeregM and regwriteM are all true; forwardbD follows the same rule using rtD.
- REQ-017 forwardaE SHALL select its source in this priority:
  - 2'b10 when rsE matches M with regwriteM.
  - else 2'b01 when rsE matches W with regwriteW.
  - else 2'b00.
  - forwardbE applies the same rule to rtE.
- REQ-018 The load-use hazard lw SHALL be asserted when memtoregE, writeregE!=0 and writeregE equals rsD or rtD.
- REQ-019 The branch hazard br SHALL be asserted when branchD and either:
  - regwriteE, with writeregE equal to rsD or rtD and nonzero; or
  - memtoregM, with writeregM equal to rsD or rtD and nonzero.
- REQ-020 The multi-cycle unit SHALL hold three state items: busy, a dest register (AW bits) and a down-counter cnt (LAT_W bits).
- REQ-021 Launch SHALL occur when issueD & mcopD & ~stallD & ~mispredictE.
  - On launch: busy=1, dest=writeregD, cnt=max(mclatD,1).
- REQ-022 While busy, cnt SHALL decrement by 1 each cycle.
  - In the cycle cnt==1, busy SHALL clear at the next edge.
  - A launch in that same cycle SHALL re-arm the unit instead; launch wins.
- REQ-023 The multi-cycle hazard mc SHALL be asserted when busy and issueD, and any of:
  - rsD or rtD equals a nonzero dest (RAW);
  - regwriteD and writeregD equals dest (WAW);
  - mcopD (structural).
- REQ-024 The hazard outputs SHALL be driven as follows:
  - stallF = stallD = flushE = (lw|br|mc) & ~mispredictE.
  - flushD = mispredictE.
- REQ-025 mispredictE SHALL also force flushE=1 and suppress launch; busy state from an earlier launch SHALL be unaffected.
- REQ-026 mcbusy SHALL equal busy, registered with no combinational path from inputs.

Reset
- REQ-027 rst SHALL asynchronously clear busy, dest and cnt (plus the counters in REQ-029).
- REQ-028 While rst is high, stallF, stallD, flushD and flushE SHALL be 0, and forwarding outputs SHALL remain combinational.
  - A reset during an active multi-cycle operation SHALL abandon that operation, and the unit is idle on the first edge after release.

Configuration
- REQ-029 With HAZ_PERF_CNT_EN defined, the block SHALL add three 32-bit wrapping outputs, each counting cycles with stallD=1:
  - cnt_lw counts stall cycles caused by lw.
  - cnt_br counts stall cycles caused by br with ~lw.
  - cnt_mc counts stall cycles caused by mc with ~lw & ~br.
- REQ-030 Without HAZ_PERF_CNT_EN, those ports and registers SHALL NOT exist and the behaviour is otherwise identical.

Structure
- REQ-031 Package hazard_pkg SHALL hold:
  - the forward encodings FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the AW and LAT_W defaults.
- REQ-032 The busy/dest/cnt tracker SHALL be sub-module hazard_mc_tracker. The top level holds forwarding, hazard combine and counters.

Verification
- REQ-033 Load-use: lw $8 in E (memtoregE=1, writeregE=8), rsD=8 -> stallF=stallD=flushE=1 for one cycle, then 0.
- REQ-034 Forward priority: rsE=5, writeregM=5, writeregW=5, both regwrite=1 -> forwardaE=10; with writeregM=0 -> 01; with rsE=0 -> 00.
- REQ-035 Div latency: launch with mclatD=4, writeregD=9 -> mcbusy high exactly 4 cycles.
  - A following add with rsD=9 stalls for those 4 cycles.
  - mclatD=0 gives 1 busy cycle.
- REQ-036 Structural and back-to-back cases:
  - A second mcop while busy is stalled until cnt==1.
  - It launches in the cycle busy would clear, and mcbusy shows no gap.
- REQ-037 Mispredict with a concurrent load-use hazard:
  - flushD=flushE=1 and stallF=stallD=0.
  - An mcop in D is not launched.
- REQ-038 Reset: assert rst mid-divide (cnt=2) -> mcbusy=0 immediately, with no stall after release.
  - With HAZ_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: forward-mux encodings and default widths.
package hazard_pkg;

    localparam int AW_DEF    = 5;
    localparam int LAT_W_DEF = 4;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_mc_tracker.sv
// Multi-cycle (mul/div) occupancy tracker: busy flag, destination register and latency down-counter.
module hazard_mc_tracker
    import hazard_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch_i,
    input  logic [AW-1:0]    dest_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             busy_o,
    output logic [AW-1:0]    dest_o,
    output logic             last_o
);

    logic             busy_q, busy_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            dest_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            dest_q <= dest_d;
            cnt_q  <= cnt_d;
        end
    end

    // A launch in the final busy cycle re-arms the unit so occupancy has no gap.
    always_comb begin
        busy_d = busy_q;
        dest_d = dest_q;
        cnt_d  = cnt_q;
        if (launch_i) begin
            busy_d = 1'b1;
            dest_d = dest_i;
            cnt_d  = (lat_i == '0) ? LAT_W'(1) : lat_i;
        end else if (busy_q) begin
            cnt_d = cnt_q - LAT_W'(1);
            if (cnt_q == LAT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign dest_o = dest_q;
    assign last_o = busy_q && (cnt_q == LAT_W'(1));

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard scoreboard: forwarding selects, load-use/branch/multi-cycle stalls and flushes.
// Defining HAZ_PERF_CNT_EN adds 32-bit stall-cause counters cnt_lw, cnt_br and cnt_mc.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rsD,
    input  logic [AW-1:0]    rtD,
    input  logic [AW-1:0]    writeregD,
    input  logic             branchD,
    input  logic             regwriteD,
    input  logic             issueD,
    input  logic             mcopD,
    input  logic [LAT_W-1:0] mclatD,
    input  logic [AW-1:0]    rsE,
    input  logic [AW-1:0]    rtE,
    input  logic [AW-1:0]    writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic [AW-1:0]    writeregM,
    input  logic             regwriteM,
    input  logic             memtoregM,
    input  logic [AW-1:0]    writeregW,
    input  logic             regwriteW,
    input  logic             mispredictE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             mcbusy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      cnt_lw,
    output logic [31:0]      cnt_br,
    output logic [31:0]      cnt_mc
`endif
);

    logic          mc_busy, mc_last, launch;
    logic [AW-1:0] mc_dest;
    logic          haz_lw, haz_br, haz_mc, haz_any;

    assign forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
    assign forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);

    assign forwardaE = ((rsE != '0) && regwriteM && (rsE == writeregM)) ? FWD_M :
                       ((rsE != '0) && regwriteW && (rsE == writeregW)) ? FWD_W : FWD_NONE;
    assign forwardbE = ((rtE != '0) && regwriteM && (rtE == writeregM)) ? FWD_M :
                       ((rtE != '0) && regwriteW && (rtE == writeregW)) ? FWD_W : FWD_NONE;

    assign haz_lw = memtoregE && (writeregE != '0) &&
                    ((writeregE == rsD) || (writeregE == rtD));

    assign haz_br = branchD &&
                    ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

    // The structural term drops in the final busy cycle so a queued mcop can re-arm the unit.
    assign haz_mc = mc_busy && issueD &&
                    (((mc_dest != '0) && ((rsD == mc_dest) || (rtD == mc_dest))) ||
                     (regwriteD && (writeregD == mc_dest)) ||
                     (mcopD && !mc_last));

    assign haz_any = (haz_lw || haz_br || haz_mc) && !mispredictE && !rst;

    assign stallF = haz_any;
    assign stallD = haz_any;
    assign flushE = haz_any || (mispredictE && !rst);
    assign flushD = mispredictE && !rst;

    assign launch = issueD && mcopD && !stallD && !mispredictE;

    hazard_mc_tracker #(
        .AW    (AW),
        .LAT_W (LAT_W)
    ) u_mc_tracker (
        .clk      (clk),
        .rst      (rst),
        .launch_i (launch),
        .dest_i   (writeregD),
        .lat_i    (mclatD),
        .busy_o   (mc_busy),
        .dest_o   (mc_dest),
        .last_o   (mc_last)
    );

    assign mcbusy = mc_busy;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] cnt_lw_q, cnt_br_q, cnt_mc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lw_q <= '0;
            cnt_br_q <= '0;
            cnt_mc_q <= '0;
        end else begin
            if (stallD && haz_lw)                       cnt_lw_q <= cnt_lw_q + 32'd1;
            if (stallD && haz_br && !haz_lw)            cnt_br_q <= cnt_br_q + 32'd1;
            if (stallD && haz_mc && !haz_lw && !haz_br) cnt_mc_q <= cnt_mc_q + 32'd1;
        end
    end

    assign cnt_lw = cnt_lw_q;
    assign cnt_br = cnt_br_q;
    assign cnt_mc = cnt_mc_q;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed self-checking bench for hazard_sb; counter checks are built only with HAZ_PERF_CNT_EN.
module tb_hazard_sb;

    logic       clk, rst;
    logic [4:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, regwriteD, issueD, mcopD;
    logic [3:0] mclatD;
    logic       regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, mispredictE;
    logic       stallF, stallD, flushD, flushE, forwardaD, forwardbD, mcbusy;
    logic [1:0] forwardaE, forwardbE;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] cnt_lw, cnt_br, cnt_mc;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_sb dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
        .branchD(branchD), .regwriteD(regwriteD), .issueD(issueD), .mcopD(mcopD),
        .mclatD(mclatD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .mispredictE(mispredictE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .mcbusy(mcbusy)
`ifdef HAZ_PERF_CNT_EN
        , .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_mc(cnt_mc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rsD = 0; rtD = 0; writeregD = 0; branchD = 0; regwriteD = 0; issueD = 0; mcopD = 0;
        mclatD = 0; rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
        writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 0; regwriteW = 0;
        mispredictE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        memtoregE = 1; writeregE = 8; rsD = 8; mispredictE = 1;
        rsE = 5; writeregM = 5; regwriteM = 1;
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {stallF, stallD, flushD, flushE});
        end
        checks++;
        if (mcbusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mcbusy got=%b want=0", mcbusy);
        end
        checks++;
        if (forwardaE !== 2'b10) begin
            failures++;
            $display("FAIL reset_fwd_comb got=%b want=10", forwardaE);
        end
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_forward();
        idle();
        rsE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
        #1;
        checks++;
        if (forwardaE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_prio_m got=%b want=10", forwardaE);
        end
        writeregM = 0;
        #1;
        checks++;
        if (forwardaE !== 2'b01) begin
            failures++;
            $display("FAIL fwd_w got=%b want=01", forwardaE);
        end
        rsE = 0; writeregW = 0;
        #1;
        checks++;
        if (forwardaE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_zero got=%b want=00", forwardaE);
        end
        idle();
        rtE = 7; writeregW = 7; regwriteW = 1; writeregM = 7; regwriteM = 0;
        #1;
        checks++;
        if (forwardbE !== 2'b01) begin
            failures++;
            $display("FAIL fwdb_w got=%b want=01", forwardbE);
        end
        idle();
        rsD = 3; rtD = 4; writeregM = 4; regwriteM = 1;
        #1;
        checks++;
        if ({forwardaD, forwardbD} !== 2'b01) begin
            failures++;
            $display("FAIL fwd_d got=%b want=01", {forwardaD, forwardbD});
        end
        rsD = 0; rtD = 0; writeregM = 0;
        #1;
        checks++;
        if ({forwardaD, forwardbD} !== 2'b00) begin
            failures++;
            $display("FAIL fwd_d_r0 got=%b want=00", {forwardaD, forwardbD});
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        memtoregE = 1; writeregE = 8; regwriteE = 1; rsD = 8; rtD = 2;
        #1;
        checks++;
        if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
            failures++;
            $display("FAIL lw_stall got=%b want=1110", {stallF, stallD, flushE, flushD});
        end
        tick();
        memtoregE = 0; regwriteE = 0; writeregE = 0;
        memtoregM = 1; writeregM = 8; regwriteM = 1;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            failures++;
            $display("FAIL lw_release got=%b want=000", {stallF, stallD, flushE});
        end
        idle();
        memtoregE = 1; writeregE = 0; rsD = 0;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            failures++;
            $display("FAIL lw_r0 got=%b want=0", stallD);
        end
        idle();
        tick();
    endtask

    task automatic test_branch();
        idle();
        branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; rsD = 1;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            failures++;
            $display("FAIL br_e got=%b want=1", stallD);
        end
        idle();
        branchD = 1; memtoregM = 1; writeregM = 4; rsD = 4;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            failures++;
            $display("FAIL br_m got=%b want=1", stallD);
        end
        branchD = 0;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            failures++;
            $display("FAIL br_nobranch got=%b want=0", stallD);
        end
        idle();
        tick();
    endtask

    task automatic test_div_latency();
        idle();
        issueD = 1; mcopD = 1; mclatD = 4; writeregD = 9; regwriteD = 1;
        #1;
        checks++;
        if ({mcbusy, stallD} !== 2'b00) begin
            failures++;
            $display("FAIL div_pre got=%b want=00", {mcbusy, stallD});
        end
        tick();
        mcopD = 0; mclatD = 0; rsD = 9; writeregD = 10;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({mcbusy, stallD} !== 2'b11) begin
                failures++;
                $display("FAIL div_busy%0d got=%b want=11", k, {mcbusy, stallD});
            end
            tick();
        end
        checks++;
        if ({mcbusy, stallD} !== 2'b00) begin
            failures++;
            $display("FAIL div_done got=%b want=00", {mcbusy, stallD});
        end
        idle();
        issueD = 1; mcopD = 1; mclatD = 0; writeregD = 6;
        tick();
        idle();
        #1;
        checks++;
        if (mcbusy !== 1'b1) begin
            failures++;
            $display("FAIL lat0_busy got=%b want=1", mcbusy);
        end
        tick();
        checks++;
        if (mcbusy !== 1'b0) begin
            failures++;
            $display("FAIL lat0_done got=%b want=0", mcbusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_stall;
        idle();
        issueD = 1; mcopD = 1; mclatD = 3; writeregD = 9; regwriteD = 1;
        tick();
        mclatD = 2; writeregD = 11; rsD = 1; rtD = 2;
        exp_stall = 3'b110;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mcbusy, stallD} !== {1'b1, exp_stall[2-k]}) begin
                failures++;
                $display("FAIL b2b_first%0d got=%b want=%b", k, {mcbusy, stallD}, {1'b1, exp_stall[2-k]});
            end
            tick();
        end
        mcopD = 0; mclatD = 0; writeregD = 11;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({mcbusy, stallD} !== 2'b11) begin
                failures++;
                $display("FAIL b2b_second%0d got=%b want=11", k, {mcbusy, stallD});
            end
            tick();
        end
        checks++;
        if ({mcbusy, stallD} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_done got=%b want=00", {mcbusy, stallD});
        end
        idle();
        tick();
    endtask

    task automatic test_mispredict();
        idle();
        memtoregE = 1; writeregE = 8; rsD = 8; mispredictE = 1;
        issueD = 1; mcopD = 1; mclatD = 3; writeregD = 12;
        #1;
        checks++;
        if ({flushD, flushE, stallF, stallD} !== 4'b1100) begin
            failures++;
            $display("FAIL mp_ctrl got=%b want=1100", {flushD, flushE, stallF, stallD});
        end
        tick();
        idle();
        #1;
        checks++;
        if (mcbusy !== 1'b0) begin
            failures++;
            $display("FAIL mp_nolaunch got=%b want=0", mcbusy);
        end
        issueD = 1; mcopD = 1; mclatD = 2; writeregD = 13;
        tick();
        idle();
        mispredictE = 1;
        tick();
        mispredictE = 0;
        #1;
        checks++;
        if (mcbusy !== 1'b1) begin
            failures++;
            $display("FAIL mp_keepbusy got=%b want=1", mcbusy);
        end
        tick();
        checks++;
        if (mcbusy !== 1'b0) begin
            failures++;
            $display("FAIL mp_busydone got=%b want=0", mcbusy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        issueD = 1; mcopD = 1; mclatD = 3; writeregD = 9;
        tick();
        idle();
        tick();
        checks++;
        if (mcbusy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_busy got=%b want=1", mcbusy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mcbusy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got=%b want=0", mcbusy);
        end
        tick();
        rst = 1'b0;
        issueD = 1; rsD = 9; regwriteD = 1; writeregD = 10;
        #1;
        checks++;
        if ({mcbusy, stallD} !== 2'b00) begin
            failures++;
            $display("FAIL rmid_after got=%b want=00", {mcbusy, stallD});
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if ({cnt_lw, cnt_br, cnt_mc} !== 96'd0) begin
            failures++;
            $display("FAIL rmid_cnt got=%0d/%0d/%0d want=0/0/0", cnt_lw, cnt_br, cnt_mc);
        end
`endif
        idle();
        tick();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        idle();
        memtoregE = 1; writeregE = 8; rsD = 8; branchD = 1; regwriteE = 1;
        tick();
        tick();
        idle();
        branchD = 1; regwriteE = 1; writeregE = 3; rsD = 3;
        tick();
        idle();
        memtoregE = 1; writeregE = 8; rsD = 8; mispredictE = 1;
        tick();
        idle();
        #1;
        checks++;
        if (cnt_lw !== 32'd2 || cnt_br !== 32'd1 || cnt_mc !== 32'd0) begin
            failures++;
            $display("FAIL perf_cnt got=%0d/%0d/%0d want=2/1/0", cnt_lw, cnt_br, cnt_mc);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_div_latency();
        test_back_to_back();
        test_mispredict();
        test_reset_mid();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
